// File: rtl/f3m_pkg.sv
// Shared constants for GF(3^m) controllers: field size, counter width,
// reduction trinomial x^M + x^K + 2, FSM encodings and mod-3 helpers.
package f3m_pkg;

  localparam int F3M_M  = 97;
  localparam int F3M_CW = 8;
  // x^M is congruent to 2*x^K + 1, from the trinomial x^97 + x^12 + 2
  localparam int F3M_K  = 12;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_RUN  = 2'd1;
  localparam logic [1:0] ST_FIN  = 2'd2;

  function automatic logic [1:0] add3(input logic [1:0] x, input logic [1:0] y);
    logic [2:0] s;
    s = {1'b0, x} + {1'b0, y};
    if (s >= 3'd3) s = s - 3'd3;
    return s[1:0];
  endfunction

  // Swapping the two bits maps 1<->2 and leaves 0 alone, i.e. negation mod 3
  function automatic logic [1:0] neg3(input logic [1:0] x);
    return {x[0], x[1]};
  endfunction

endpackage

// File: rtl/f3m_cubic.sv
// Combinational Frobenius map c = a^3 in GF(3^M): spread coefficient i to
// position 3i, then fold the high coefficients back with mod-3 additions.
module f3m_cubic
  import f3m_pkg::*;
#(
  parameter int M = F3M_M,
  parameter int K = F3M_K
) (
  input  logic [2*M-1:0] a_i,
  output logic [2*M-1:0] c_o
);

  localparam int D = 3*M - 2;

  logic [1:0] p [D];

  // Fold from the top so each folded term only lands on lower, unfolded slots
  always_comb begin
    c_o = '0;
    for (int d = 0; d < D; d++) p[d] = 2'b00;
    for (int i = 0; i < M; i++) p[3*i] = a_i[2*i +: 2];
    for (int d = D - 1; d >= M; d--) begin
      p[d-M+K] = add3(p[d-M+K], neg3(p[d]));
      p[d-M]   = add3(p[d-M], p[d]);
    end
    for (int i = 0; i < M; i++) c_o[2*i +: 2] = p[i];
  end

endmodule

// File: rtl/f3m_cubic_seq.sv
// Sequential repeated cubing: computes a^(3^n) with one Frobenius step per
// cycle, then presents the result on c with a one-cycle done pulse.
module f3m_cubic_seq
  import f3m_pkg::*;
#(
  parameter int M  = F3M_M,
  parameter int CW = F3M_CW
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            start,
  input  logic [CW-1:0]   n,
  input  logic [2*M-1:0]  a,
  output logic [2*M-1:0]  c,
  output logic            busy,
  output logic            done
);

  logic [1:0]     state_q, state_d;
  logic [CW-1:0]  cnt_q, cnt_d;
  logic [2*M-1:0] work_q, work_d;
  logic [2*M-1:0] c_q, c_d;
  logic           done_q, done_d;
  logic [2*M-1:0] cube;

  f3m_cubic #(.M(M), .K(F3M_K)) u_cubic (
    .a_i (work_q),
    .c_o (cube)
  );

  // Inputs are only looked at in IDLE, so a start while busy has no effect
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    work_d  = work_q;
    c_d     = c_q;
    done_d  = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          work_d  = a;
          cnt_d   = n;
          state_d = (n == '0) ? ST_FIN : ST_RUN;
        end
      end
      ST_RUN: begin
        work_d = cube;
        cnt_d  = cnt_q - CW'(1);
        if (cnt_q == CW'(1)) state_d = ST_FIN;
      end
      ST_FIN: begin
        c_d     = work_q;
        done_d  = 1'b1;
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      work_q  <= '0;
      c_q     <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      work_q  <= work_d;
      c_q     <= c_d;
      done_q  <= done_d;
    end
  end

  assign busy = (state_q != ST_IDLE);
  assign done = done_q;
  assign c    = c_q;

endmodule
